// File: rtl/hop_chain_param.sv
// hop_chain_param: a DEPTH-stage shift chain with per-stage valid and tag
// bits, per-stage synchronous clear, a valid-count output and a probe FSM.
// The probe tags one beat and measures how many edges it takes to reach
// the last stage, with stalled edges included.
module hop_chain_param #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 7,
  parameter int CNT_W = 8
) (
  input  logic                           clock0,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               din,
  input  logic                           din_valid,
  input  logic                           advance,
  input  logic [DEPTH-1:0]               stage_clr,
  input  logic                           probe_arm,
  output logic [WIDTH-1:0]               dout,
  output logic                           dout_valid,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic                           probe_busy,
  output logic                           probe_done,
  output logic [CNT_W-1:0]               probe_latency,
  output logic                           probe_lost
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    MEAS  = 2'd2,
    DONE  = 2'd3
  } probe_state_t;

  // Chain storage
  logic [WIDTH-1:0] data_reg  [DEPTH];
  logic [WIDTH-1:0] data_next [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] tag_reg;
  logic [DEPTH-1:0] tag_next;

  // Probe state
  probe_state_t     state_reg;
  probe_state_t     state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] lat_reg;
  logic [CNT_W-1:0] lat_next;
  logic             lost_reg;
  logic             lost_next;

  // FSM-to-chain controls
  logic capture;     // tag the beat entering stage 0 on this edge
  logic tags_flush;  // drop any stale tag so a fresh arm starts with none

  // Tag events observed from the current register contents
  logic tag_hit;       // the stage holding the tag is being cleared
  logic tag_dest_hit;  // the tag is moving into a stage being cleared
  logic tag_arrive;    // the tag is moving into the last stage

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign tag_hit      = |(tag_reg & stage_clr);
  assign tag_dest_hit = advance & (|(tag_reg[DEPTH-2:0] & stage_clr[DEPTH-1:1]));
  assign tag_arrive   = advance & tag_reg[DEPTH-2];

  // Probe FSM next-state, counter and result logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lat_next   = lat_reg;
    lost_next  = lost_reg;
    capture    = 1'b0;
    tags_flush = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (probe_arm) begin
          state_next = ARMED;
          lat_next   = '0;
          lost_next  = 1'b0;
          tags_flush = 1'b1;
        end
      end
      ARMED: begin
        if (advance && din_valid) begin
          capture  = 1'b1;
          cnt_next = CNT_ONE;
          if (stage_clr[0]) begin
            // The tagged beat is wiped on the very edge it enters.
            state_next = DONE;
            lost_next  = 1'b1;
            lat_next   = '0;
          end else begin
            state_next = MEAS;
          end
        end
      end
      MEAS: begin
        cnt_next = sat_inc(cnt_reg);
        if (tag_hit || tag_dest_hit) begin
          // A clear reaching the tag beats a simultaneous arrival.
          state_next = DONE;
          lost_next  = 1'b1;
          lat_next   = '0;
        end else if (tag_arrive) begin
          state_next = DONE;
          lat_next   = sat_inc(cnt_reg);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Chain next-state: shift or hold, then tag flush, then per-stage clear
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_next[i] = data_reg[i];
    end
    valid_next = valid_reg;
    tag_next   = tag_reg;
    if (advance) begin
      data_next[0] = din;
      valid_next[0] = din_valid;
      tag_next[0]   = capture;
      for (int i = 1; i < DEPTH; i++) begin
        // Stage i takes the pre-clear contents of stage i-1.
        data_next[i]  = data_reg[i-1];
        valid_next[i] = valid_reg[i-1];
        tag_next[i]   = tag_reg[i-1];
      end
    end
    if (tags_flush) begin
      tag_next = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (stage_clr[i]) begin
        data_next[i]  = '0;
        valid_next[i] = 1'b0;
        tag_next[i]   = 1'b0;
      end
    end
  end

  // State registers for chain and probe, reset overrides everything
  always_ff @(posedge clock0) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_reg[i] <= '0;
      end
      valid_reg <= '0;
      tag_reg   <= '0;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      lat_reg   <= '0;
      lost_reg  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_reg[i] <= data_next[i];
      end
      valid_reg <= valid_next;
      tag_reg   <= tag_next;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      lat_reg   <= lat_next;
      lost_reg  <= lost_next;
    end
  end

  // Occupancy as a prefix sum over the valid bits
  logic [OCC_W-1:0] occ_sum [DEPTH+1];
  assign occ_sum[0] = '0;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
    assign occ_sum[gi+1] = occ_sum[gi] + OCC_W'(valid_reg[gi]);
  end

  assign occupancy     = occ_sum[DEPTH];
  assign dout          = data_reg[DEPTH-1];
  assign dout_valid    = valid_reg[DEPTH-1];
  assign probe_busy    = (state_reg == ARMED) || (state_reg == MEAS);
  assign probe_done    = (state_reg == DONE);
  assign probe_latency = lat_reg;
  assign probe_lost    = lost_reg;

endmodule

// File: tb/tb_hop_chain_param.sv
// Scoreboard bench for hop_chain_param (WIDTH=8, DEPTH=7, CNT_W=8).
module tb_hop_chain_param;

  logic       clock0 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       advance = 1'b0;
  logic [6:0] stage_clr = '0;
  logic       probe_arm = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] occupancy;
  logic       probe_busy;
  logic       probe_done;
  logic [7:0] probe_latency;
  logic       probe_lost;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] sb_q [$];

  hop_chain_param #(.WIDTH(8), .DEPTH(7), .CNT_W(8)) dut (
    .clock0        (clock0),
    .rst           (rst),
    .din           (din),
    .din_valid     (din_valid),
    .advance       (advance),
    .stage_clr     (stage_clr),
    .probe_arm     (probe_arm),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .occupancy     (occupancy),
    .probe_busy    (probe_busy),
    .probe_done    (probe_done),
    .probe_latency (probe_latency),
    .probe_lost    (probe_lost)
  );

  always #5 clock0 = ~clock0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One clock edge with the given inputs; afterwards the scoreboard pops a
  // beat whenever an advancing edge put a valid beat into the last stage.
  task automatic tick(input logic [7:0] d, input logic dv, input logic adv,
                      input logic [6:0] clr, input logic arm, input logic r);
    logic [7:0] exp;
    din = d; din_valid = dv; advance = adv; stage_clr = clr;
    probe_arm = arm; rst = r;
    @(posedge clock0);
    #1;
    if (adv && !r && dout_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_beat", {24'd0, dout}, 32'hFFFF_FFFF);
      end else begin
        exp = sb_q.pop_front();
        check("sb_dout", {24'd0, dout}, {24'd0, exp});
        $display("[sb] beat out dout=0x%02h expected=0x%02h", dout, exp);
      end
    end
  endtask

  // Send one valid beat on an advancing edge and record it as expected.
  task automatic send(input logic [7:0] d, input logic expect_out);
    if (expect_out) sb_q.push_back(d);
    tick(d, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0);
  endtask

  task automatic idle_adv(input int n);
    for (int i = 0; i < n; i++) tick(8'h00, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0);
  endtask

  // Advance until probe_done, bounded; an expired bound is a failed check.
  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!probe_done && k < budget) begin
      tick(8'h00, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0);
      k++;
    end
    check("probe_done_within_budget", {31'd0, probe_done}, 32'd1);
  endtask

  initial begin
    logic saw_valid;

    // Reset state
    for (int i = 0; i < 3; i++) tick(8'hFF, 1'b1, 1'b1, 7'h00, 1'b1, 1'b1);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_occupancy", {29'd0, occupancy}, 32'd0);
    check("rst_busy", {31'd0, probe_busy}, 32'd0);
    check("rst_done", {31'd0, probe_done}, 32'd0);
    check("rst_latency", {24'd0, probe_latency}, 32'd0);
    check("rst_lost", {31'd0, probe_lost}, 32'd0);

    // Single beat transit: exactly 7 edges, one cycle wide
    send(8'hA5, 1'b1);
    check("transit_occ_e1", {29'd0, occupancy}, 32'd1);
    for (int k = 2; k <= 8; k++) begin
      tick(8'h00, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0);
      check($sformatf("transit_valid_e%0d", k), {31'd0, dout_valid}, (k == 7) ? 32'd1 : 32'd0);
      check($sformatf("transit_occ_e%0d", k), {29'd0, occupancy}, (k <= 7) ? 32'd1 : 32'd0);
    end
    check("sb_drain_transit", sb_q.size(), 32'd0);

    // Probe with a 3-cycle stall mid-transit
    tick(8'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
    check("arm_busy", {31'd0, probe_busy}, 32'd1);
    send(8'h3C, 1'b1);
    idle_adv(2);
    for (int i = 0; i < 3; i++) tick(8'h00, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0);
    wait_done(20);
    check("stall_latency", {24'd0, probe_latency}, 32'd10);
    check("stall_lost", {31'd0, probe_lost}, 32'd0);
    check("stall_busy", {31'd0, probe_busy}, 32'd0);
    check("sb_drain_stall", sb_q.size(), 32'd0);
    idle_adv(2);

    // Clear the stage holding the tag
    tick(8'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
    check("rearm_clears_latency", {24'd0, probe_latency}, 32'd0);
    send(8'h77, 1'b0);
    idle_adv(3);
    tick(8'h00, 1'b0, 1'b0, 7'h08, 1'b0, 1'b0);
    check("lost_done", {31'd0, probe_done}, 32'd1);
    check("lost_flag", {31'd0, probe_lost}, 32'd1);
    check("lost_latency", {24'd0, probe_latency}, 32'd0);
    check("lost_occupancy", {29'd0, occupancy}, 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(8'h00, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0);
      if (dout_valid) saw_valid = 1'b1;
    end
    check("lost_never_on_dout", {31'd0, saw_valid}, 32'd0);

    // Fill then drain, occupancy steps down
    for (int i = 0; i < 7; i++) send(8'h10 + 8'(i), 1'b1);
    check("fill_occupancy", {29'd0, occupancy}, 32'd7);
    for (int i = 6; i >= 0; i--) begin
      tick(8'h00, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0);
      check($sformatf("drain_occ_%0d", i), {29'd0, occupancy}, i);
    end
    check("sb_drain_fill", sb_q.size(), 32'd0);

    // Clear-all on a full chain
    for (int i = 0; i < 7; i++) send(8'h20 + 8'(i), 1'b1);
    check("refill_occupancy", {29'd0, occupancy}, 32'd7);
    tick(8'h00, 1'b0, 1'b1, 7'h7F, 1'b0, 1'b0);
    check("clr_all_occupancy", {29'd0, occupancy}, 32'd0);
    check("clr_all_valid", {31'd0, dout_valid}, 32'd0);
    sb_q.delete();

    // Reset during measurement with a full chain
    for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), 1'b1);
    tick(8'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
    send(8'h36, 1'b1);
    check("meas_busy", {31'd0, probe_busy}, 32'd1);
    check("meas_full", {29'd0, occupancy}, 32'd7);
    tick(8'h00, 1'b0, 1'b1, 7'h7F, 1'b1, 1'b1);
    sb_q.delete();
    check("midrst_dout", {24'd0, dout}, 32'd0);
    check("midrst_valid", {31'd0, dout_valid}, 32'd0);
    check("midrst_occ", {29'd0, occupancy}, 32'd0);
    check("midrst_busy", {31'd0, probe_busy}, 32'd0);
    check("midrst_done", {31'd0, probe_done}, 32'd0);
    check("midrst_latency", {24'd0, probe_latency}, 32'd0);
    check("midrst_lost", {31'd0, probe_lost}, 32'd0);
    tick(8'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
    send(8'h99, 1'b1);
    wait_done(20);
    check("remeasure_latency", {24'd0, probe_latency}, 32'd7);
    check("remeasure_lost", {31'd0, probe_lost}, 32'd0);
    check("sb_drain_remeasure", sb_q.size(), 32'd0);

    // Long stall saturates the counter
    tick(8'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
    send(8'h42, 1'b1);
    for (int i = 0; i < 300; i++) tick(8'h00, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0);
    check("sat_still_busy", {31'd0, probe_busy}, 32'd1);
    wait_done(20);
    check("sat_latency", {24'd0, probe_latency}, 32'd255);
    check("sb_drain_sat", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hop_chain_param.md
HOP_CHAIN_PARAM -- requirements
Module: hop_chain_param

Interface
REQ-001 SHALL have parameter WIDTH, default 1: data bits per stage.
REQ-002 SHALL have parameter DEPTH, default 7: number of flop stages; legal range 2..64.
REQ-003 SHALL have parameter CNT_W, default 8: latency counter width.
REQ-004 SHALL have port clock0  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port din  input  WIDTH  data into stage 0.
REQ-007 SHALL have port din_valid  input  1  din qualifier.
REQ-008 SHALL have port advance  input  1  chain shift enable; 0 = all stages hold.
REQ-009 SHALL have port stage_clr  input  DEPTH  per-stage synchronous clear, bit i -> stage i.
REQ-010 SHALL have port probe_arm  input  1  arms the latency probe.
REQ-011 SHALL have port dout  output  WIDTH  data of stage DEPTH-1.
REQ-012 SHALL have port dout_valid  output  1  valid of stage DEPTH-1.
REQ-013 SHALL have port occupancy  output  clog2(DEPTH+1)  count of valid stages.
REQ-014 SHALL have port probe_busy  output  1  probe in ARMED or MEAS.
REQ-015 SHALL have port probe_done  output  1  probe in DONE.
REQ-016 SHALL have port probe_latency  output  CNT_W  measured hop latency, cycles.
REQ-017 SHALL have port probe_lost  output  1  tagged beat cleared before reaching last stage.

Function
REQ-018 Each stage i SHALL hold data[i], valid[i], tag[i] registers.
REQ-019 advance=1: stage 0 SHALL load {din, din_valid, capture}, stage i SHALL load stage i-1 (i>0).
REQ-020 advance=0: all stages SHALL hold; din ignored.
REQ-021 stage_clr[i]=1 SHALL zero data[i], valid[i], tag[i] at that edge, overriding shift/hold; stage i+1 SHALL still receive the pre-clear contents of stage i when advance=1.
REQ-022 dout/dout_valid SHALL be driven directly from stage DEPTH-1 registers; continuous advance gives din-to-dout latency of exactly DEPTH edges.
REQ-023 occupancy SHALL equal popcount of valid[DEPTH-1:0], combinational from registers.
REQ-024 Probe FSM SHALL have states IDLE, ARMED, MEAS, DONE.
REQ-025 IDLE or DONE with probe_arm=1 SHALL go to ARMED; probe_latency and probe_lost cleared on that edge.
REQ-026 ARMED with advance=1 and din_valid=1 SHALL assert capture (tag=1 into stage 0), set counter to 1, go to MEAS.
REQ-027 MEAS: each edge SHALL increment counter, saturating at 2^CNT_W-1, stalled cycles included.
REQ-028 MEAS: at the edge loading tag into stage DEPTH-1, SHALL store probe_latency = counter+1 (saturated) and go to DONE; continuous advance gives DEPTH.
REQ-029 MEAS: if stage_clr clears the stage holding the tag, SHALL set probe_lost=1, probe_latency=0, go to DONE; clear wins over simultaneous arrival.
REQ-030 probe_arm SHALL be ignored in ARMED and MEAS.
REQ-031 At most one tag SHALL exist in the chain at any time.

Reset
REQ-032 rst=1 SHALL, at the edge, zero all data, valid and tag bits, counter and probe_latency, clear probe_lost, set FSM to IDLE; rst overrides advance, stage_clr and probe_arm.
REQ-033 After reset, outputs SHALL be: dout=0, dout_valid=0, occupancy=0, probe_busy=0, probe_done=0, probe_latency=0, probe_lost=0.
REQ-034 rst mid-MEAS SHALL abort measurement with no DONE pulse.

Verification (WIDTH=8, DEPTH=7, CNT_W=8)
REQ-035 din=0xA5, din_valid=1 for one cycle, advance=1 held -> dout=0xA5, dout_valid=1 exactly 7 edges later, one cycle wide; occupancy 1 throughout transit.
REQ-036 probe_arm, then valid beat, advance low for 3 cycles mid-transit -> probe_done=1, probe_latency=10, probe_lost=0.
REQ-037 Probe armed, tagged beat in stage 3, stage_clr=0x08 -> probe_lost=1, probe_latency=0, probe_done=1; beat never appears on dout.
REQ-038 Fill 7 valid beats, advance=1, din_valid=0 -> occupancy steps 7,6,...,0; stage_clr=0x7F on full chain -> occupancy 0 next edge.
REQ-039 rst asserted during MEAS with chain full -> next edge all outputs 0, FSM IDLE; re-arm then measure again -> probe_latency=7.
REQ-040 advance=0 for 300 cycles during MEAS -> probe_latency saturates at 255.
